// File: rtl/cpu_pkg.sv
// Shared encodings for the 19-bit CPU control path: instruction fields,
// opcodes, ALU select codes, sequencer states and the decoded-instruction bundle.
package cpu_pkg;

    localparam int INSTR_LEN = 19;
    localparam int OP_MSB    = 18;
    localparam int OP_LSB    = 14;
    localparam int RD_MSB    = 13;
    localparam int RD_LSB    = 11;
    localparam int RA_MSB    = 10;
    localparam int RA_LSB    = 8;
    localparam int RB_MSB    = 7;
    localparam int RB_LSB    = 5;
    localparam int ADDR_MSB  = 7;
    localparam int ADDR_LSB  = 0;

    localparam logic [4:0] OP_LD   = 5'b01000;
    localparam logic [4:0] OP_ST   = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_BEQ  = 5'b10001;
    localparam logic [4:0] OP_BNE  = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11110;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    localparam logic WD_ALU = 1'b0;
    localparam logic WD_MEM = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       is_alu;
        logic       is_ld;
        logic       is_st;
        logic       is_jmp;
        logic       is_beq;
        logic       is_bne;
        logic       is_call;
        logic       is_ret;
        logic       is_nop;
        logic       is_hlt;
        logic [3:0] alu_op;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] addr;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: one-hot class flags, ALU select
// and register/address fields for a single instruction word.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_LEN-1:0] instr,
    output dec_t                 dec
);

    logic [4:0] op;

    always_comb begin
        op         = instr[OP_MSB:OP_LSB];
        dec        = '0;
        dec.rd     = instr[RD_MSB:RD_LSB];
        dec.ra     = instr[RA_MSB:RA_LSB];
        dec.rb     = instr[RB_MSB:RB_LSB];
        dec.addr   = instr[ADDR_MSB:ADDR_LSB];
        if (op[4:3] == 2'b00) begin
            dec.is_alu = 1'b1;
            dec.alu_op = op[3:0];
        end else begin
            case (op)
                OP_LD:   dec.is_ld   = 1'b1;
                OP_ST:   dec.is_st   = 1'b1;
                OP_JMP:  dec.is_jmp  = 1'b1;
                OP_BEQ: begin
                    dec.is_beq = 1'b1;
                    dec.alu_op = ALU_SUB;
                end
                OP_BNE: begin
                    dec.is_bne = 1'b1;
                    dec.alu_op = ALU_SUB;
                end
                OP_CALL: dec.is_call = 1'b1;
                OP_RET:  dec.is_ret  = 1'b1;
                OP_HLT:  dec.is_hlt  = 1'b1;
                // Undefined opcodes fall through to NOP behaviour.
                default: dec.is_nop  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC and IR, drives the
// register-file strobes and selects, the ALU select and the data-memory handshake.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int              PC_W    = 8,
    parameter int              INSTR_W = 19,
    parameter logic [PC_W-1:0] RST_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               alu_zero,
    output logic [3:0]         alu_op,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    input  logic [PC_W-1:0]    stack_top,
    output logic               regwrite,
    output logic               push,
    output logic               pop,
    output logic [PC_W-1:0]    stack_pc,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [2:0]         ws,
    output logic               wd_sel,
    output logic               halted
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     pc_tgt;
    dec_t                dec;

    instr_decoder u_dec (
        .instr (ir_q),
        .dec   (dec)
    );

    assign pc_inc = pc_q + PC_W'(1);
    assign pc_tgt = PC_W'(dec.addr);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec.is_alu) begin
                    state_d = S_WB;
                end else if (dec.is_ld || dec.is_st) begin
                    state_d = S_MEM;
                end else if (dec.is_hlt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    if (dec.is_jmp || dec.is_call) begin
                        pc_d = pc_tgt;
                    end else if (dec.is_beq) begin
                        pc_d = alu_zero ? pc_tgt : pc_inc;
                    end else if (dec.is_bne) begin
                        pc_d = alu_zero ? pc_inc : pc_tgt;
                    end else if (dec.is_ret) begin
                        // Return address is the stack top before this cycle's pop.
                        pc_d = stack_top;
                    end else if (dec.is_nop) begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (dec.is_st) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RST_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Selects come straight from IR, so they hold from EXEC through MEM and WB.
    always_comb begin
        imem_addr = pc_q;
        rs1       = dec.ra;
        rs2       = dec.rb;
        ws        = dec.rd;
        alu_op    = dec.alu_op;
        regwrite  = (state_q == S_WB);
        wd_sel    = ((state_q == S_WB) && dec.is_ld) ? WD_MEM : WD_ALU;
        push      = (state_q == S_EXEC) && dec.is_call;
        pop       = (state_q == S_EXEC) && dec.is_ret;
        stack_pc  = push ? pc_inc : '0;
        dmem_req  = (state_q == S_MEM);
        dmem_we   = (state_q == S_MEM) && dec.is_st;
        halted    = (state_q == S_HALT);
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: strobe events are queued when a program is
// loaded and matched as the sequencer raises regwrite/push/pop.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  imem_addr;
    logic [18:0] imem_rdata = '0;
    logic        alu_zero = 1'b0;
    logic [3:0]  alu_op;
    logic        dmem_req, dmem_we;
    logic        dmem_ready = 1'b0;
    logic [7:0]  stack_top = 8'd6;
    logic        regwrite, push, pop;
    logic [7:0]  stack_pc;
    logic [2:0]  rs1, rs2, ws;
    logic        wd_sel, halted;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] mask;
    } ev_t;
    ev_t sb[$];

    logic [18:0] rom [0:255];

    cpu_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .alu_zero   (alu_zero),
        .alu_op     (alu_op),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .stack_top  (stack_top),
        .regwrite   (regwrite),
        .push       (push),
        .pop        (pop),
        .stack_pc   (stack_pc),
        .rs1        (rs1),
        .rs2        (rs2),
        .ws         (ws),
        .wd_sel     (wd_sel),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] kind, input logic [2:0] w,
                                       input logic [2:0] a, input logic [2:0] b,
                                       input logic [3:0] aop, input logic wsel,
                                       input logic [7:0] spc);
        return {8'h00, kind, w, a, b, aop, wsel, spc};
    endfunction

    function automatic logic [18:0] ins_r(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 5'b00000};
    endfunction

    function automatic logic [18:0] ins_a(input logic [4:0] op, input logic [7:0] addr);
        return {op, 6'b000000, addr};
    endfunction

    localparam logic [1:0] K_RW = 2'd1, K_PUSH = 2'd2, K_POP = 2'd3;
    logic [31:0] m_kind, m_spc, m_rw, m_aop;
    initial begin
        m_kind = mk(2'd3, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'h00);
        m_spc  = mk(2'd0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'hFF);
        m_rw   = mk(2'd3, 3'd7, 3'd7, 3'd7, 4'd0, 1'b1, 8'h00);
        m_aop  = mk(2'd0, 3'd0, 3'd0, 3'd0, 4'hF, 1'b0, 8'h00);
    end

    task automatic expect_ev(input string tag, input logic [31:0] exp, input logic [31:0] mask);
        ev_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.mask = mask;
        sb.push_back(e);
    endtask

    // Strobe monitor: every strobe cycle must match the next queued event.
    always @(negedge clk) begin
        logic [1:0]  kind;
        logic [31:0] obs;
        ev_t         e;
        if (regwrite || push || pop) begin
            chk("strobe_excl", 32'($countones({regwrite, push, pop})), 32'd1);
            kind = regwrite ? K_RW : (push ? K_PUSH : K_POP);
            obs  = mk(kind, ws, rs1, rs2, alu_op, wd_sel, stack_pc);
            if (sb.size() == 0) begin
                chk("sb_unexpected", obs, 32'd0);
            end else begin
                e = sb.pop_front();
                chk(e.tag, obs & e.mask, e.exp & e.mask);
            end
        end
    end

    task automatic load_nops();
        for (int i = 0; i < 256; i++) rom[i] = ins_a(5'b11110, 8'h00);
    endtask

    task automatic reset_dut(input int n);
        reset      = 1'b0;
        dmem_ready = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_drained(input string tag);
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_pc;
        logic       taken;

        // ADD r1,r2,r3 with reset-state checks on the release cycle.
        load_nops();
        rom[0] = 19'b00000_001_010_011_00000;
        expect_ev("add_wb", mk(K_RW, 3'd1, 3'd2, 3'd3, 4'd0, 1'b0, 8'h00), m_rw | m_aop);
        reset_dut(3);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_halted",    32'(halted), 32'd0);
        chk("rst_strobes",   32'({regwrite, push, pop, dmem_req, dmem_we, wd_sel}), 32'd0);
        chk("rst_selects",   32'({alu_op, rs1, rs2, ws, stack_pc}), 32'd0);
        wait_cyc(4);
        chk("add_next_pc", 32'(imem_addr), 32'd1);
        sb_drained("add_sb_empty");

        // CALL 0x23 at PC 5, RET at 0x23 with stack_top = 6.
        load_nops();
        rom[5]    = ins_a(5'b10011, 8'h23);
        rom[8'h23] = ins_a(5'b10100, 8'h00);
        stack_top = 8'd6;
        expect_ev("call_push", mk(K_PUSH, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'd6), m_kind | m_spc);
        expect_ev("ret_pop",   mk(K_POP,  3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'd0), m_kind);
        reset_dut(1);
        wait_cyc(18);
        chk("call_target", 32'(imem_addr), 32'h23);
        wait_cyc(3);
        chk("ret_target", 32'(imem_addr), 32'd6);
        sb_drained("callret_sb_empty");

        // LD r4,[r1]: ready three cycles after MEM entry.
        load_nops();
        rom[0] = ins_r(5'b01000, 3'd4, 3'd1, 3'd0);
        expect_ev("ld_wb", mk(K_RW, 3'd4, 3'd1, 3'd0, 4'd0, 1'b1, 8'h00), m_rw);
        reset_dut(1);
        wait_cyc(3);
        for (int i = 0; i < 4; i++) begin
            chk("ld_req", 32'({dmem_req, dmem_we}), 32'b10);
            if (i == 3) dmem_ready = 1'b1;
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        chk("ld_req_drop", 32'(dmem_req), 32'd0);
        wait_cyc(1);
        chk("ld_next_pc", 32'(imem_addr), 32'd1);
        sb_drained("ld_sb_empty");

        // ST r2 -> [r5]: one wait cycle, no register write expected.
        load_nops();
        rom[0] = ins_r(5'b01001, 3'd0, 3'd2, 3'd5);
        reset_dut(1);
        wait_cyc(3);
        for (int i = 0; i < 2; i++) begin
            chk("st_req", 32'({dmem_req, dmem_we}), 32'b11);
            if (i == 1) dmem_ready = 1'b1;
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        chk("st_req_drop", 32'(dmem_req), 32'd0);
        chk("st_next_pc", 32'(imem_addr), 32'd1);
        sb_drained("st_sb_empty");

        // BEQ/BNE 0x40 at PC 10, both polarities of alu_zero.
        for (int k = 0; k < 4; k++) begin
            load_nops();
            rom[10]  = ins_a((k < 2) ? 5'b10001 : 5'b10010, 8'h40);
            alu_zero = (k == 0) || (k == 2);
            taken    = (k == 0) || (k == 3);
            exp_pc   = taken ? 8'h40 : 8'd11;
            reset_dut(1);
            wait_cyc(32);
            chk("br_alu_op", 32'(alu_op), 32'd1);
            wait_cyc(1);
            chk("br_target", 32'(imem_addr), 32'(exp_pc));
        end
        alu_zero = 1'b0;

        // PC wrap: NOP at 255 goes to 0; CALL at 255 pushes 0.
        load_nops();
        rom[0] = ins_a(5'b10000, 8'hFF);
        reset_dut(1);
        wait_cyc(3);
        chk("jmp_ff", 32'(imem_addr), 32'hFF);
        wait_cyc(3);
        chk("nop_wrap", 32'(imem_addr), 32'd0);

        load_nops();
        rom[0]   = ins_a(5'b10000, 8'hFF);
        rom[255] = ins_a(5'b10011, 8'h10);
        expect_ev("call_wrap_push", mk(K_PUSH, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'd0), m_kind | m_spc);
        reset_dut(1);
        wait_cyc(6);
        chk("call_wrap_target", 32'(imem_addr), 32'h10);
        sb_drained("wrap_sb_empty");

        // HLT: sticky and quiet until a single-edge reset.
        load_nops();
        rom[0] = ins_a(5'b11111, 8'h00);
        reset_dut(1);
        wait_cyc(3);
        for (int i = 0; i < 20; i++) begin
            chk("halt_flag",  32'(halted), 32'd1);
            chk("halt_quiet", 32'({regwrite, push, pop, dmem_req}), 32'd0);
            @(negedge clk);
        end
        reset_dut(1);
        chk("halt_cleared", 32'(halted), 32'd0);
        chk("halt_rst_pc",  32'(imem_addr), 32'd0);

        // Reset during a MEM wait, then a stray ready pulse.
        load_nops();
        rom[0] = ins_r(5'b01000, 3'd4, 3'd1, 3'd0);
        reset_dut(1);
        wait_cyc(4);
        chk("mem_wait_req", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mem_rst_req", 32'(dmem_req), 32'd0);
        chk("mem_rst_pc",  32'(imem_addr), 32'd0);
        reset      = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("mem_rst_req2", 32'(dmem_req), 32'd0);
        wait_cyc(2);
        chk("mem_refetch_req", 32'(dmem_req), 32'd1);
        wait_cyc(3);
        sb_drained("memrst_sb_empty");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle fetch/decode/execute sequencer for the 19-bit CPU, directly upstream of reg_file. It owns the 8-bit PC and the instruction register, and drives reg_file's regwrite/push/pop/stack_pc/rs1/rs2/ws. It also drives ALU opcode select, write-data source select and the data-memory request handshake. It implements CALL/RET through the reg_file hardware stack.

Parameters:
PC_W, 8, program counter and stack_pc width
INSTR_W, 19, instruction width
RST_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (sampled on rising clk edge, 0 = reset)
imem_addr  out  PC_W  instruction address; equals PC
imem_rdata  in  INSTR_W  instruction word; synchronous ROM, valid one cycle after imem_addr
alu_zero  in  1  ALU zero flag for the current rs1/rs2 operands
alu_op  out  4  ALU operation select
dmem_req  out  1  data-memory request, held until dmem_ready
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
dmem_ready  in  1  data-memory completion, single-cycle pulse
stack_top  in  PC_W  reg_file stack top (return address)
regwrite  out  1  reg_file write strobe
push  out  1  reg_file stack push strobe
pop  out  1  reg_file stack pop strobe
stack_pc  out  PC_W  return address to push
rs1  out  3  reg_file read select 1
rs2  out  3  reg_file read select 2
ws  out  3  reg_file write select
wd_sel  out  1  write-data source: 0 = ALU result, 1 = dmem read data
halted  out  1  high after HLT until reset

Behaviour:
- Instruction fields: op=[18:14], rd=[13:11], ra=[10:8], rb=[7:5], addr=[7:0].
- Opcodes: 00000–00111 ALU (alu_op=op[3:0]); LD 01000; ST 01001; JMP 10000; BEQ 10001; BNE 10010; CALL 10011; RET 10100; NOP 11110; HLT 11111. Any other opcode executes as NOP.
- Reset (reset=0 at an edge):
  - State=FETCH, PC=RST_PC, IR=0, halted=0.
  - All strobes, dmem_req, dmem_we, alu_op, rs1, rs2, ws, wd_sel and stack_pc are 0.
  - Takes effect on the same edge, from any state, including an outstanding MEM wait (dmem_req drops; no late write).
- FETCH: drive imem_addr=PC, then go to DECODE.
- DECODE: latch IR from imem_rdata, then go to EXEC.
- EXEC: drive rs1=ra, rs2=rb, ws=rd, alu_op per class. Per class:
  - ALU: go to WB.
  - LD/ST: go to MEM.
  - JMP: PC←addr.
  - BEQ: PC←addr if alu_zero else PC+1 (alu_op=SUB).
  - BNE: the inverse of BEQ.
  - CALL: push=1 for this one cycle with stack_pc=PC+1; PC←addr.
  - RET: pop=1 for this one cycle; PC←stack_top sampled this cycle (pre-pop value).
  - NOP: PC←PC+1.
  - HLT: go to HALT.
  - Classes other than ALU, LD/ST and HLT return to FETCH.
- MEM: dmem_req=1, dmem_we=1 for ST. Hold every output stable until dmem_ready=1.
  - ST: PC←PC+1, go to FETCH.
  - LD: go to WB.
  - dmem_ready outside MEM is ignored.
- WB: regwrite=1 for exactly one cycle; wd_sel=1 for LD, else 0; PC←PC+1; go to FETCH.
- HALT: all strobes 0; halted=1; sticky until reset.
- Latency in cycles: ALU 4, branch/jump/CALL/RET/NOP 3, ST 4+N, LD 5+N (N = dmem wait cycles).
- regwrite, push and pop are mutually exclusive, each at most one cycle per instruction.
- PC arithmetic is modulo 2^PC_W: 255+1 wraps to 0, and CALL at PC=255 pushes 0.
- Stack overflow/underflow are owned by reg_file; this block performs no check.
- rs1/rs2/ws hold their EXEC values through MEM and WB.

Decomposition:
- cpu_pkg holds: opcode constants, instruction field bit positions, alu_op codes, the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT) and the wd_sel encodings.
- One combinational sub-module, instr_decoder: maps IR to class one-hots, alu_op and field outputs; it is unit-testable on its own.

Test Plan:
- Hold reset=0 for 3 cycles, release; ROM[0]=ADD r1,r2,r3 (19'b00000_001_010_011_00000) -> imem_addr=0; in WB regwrite=1 for one cycle with ws=1, rs1=2, rs2=3, alu_op=0, wd_sel=0; next FETCH imem_addr=1.
- ROM[5]=CALL 0x23, ROM[0x23]=RET, stack_top=6 -> push=1 for one cycle with stack_pc=6; next imem_addr=0x23; then pop=1 for one cycle; next imem_addr=6.
- LD r4,[r1] with dmem_ready arriving 3 cycles after MEM entry -> dmem_req=1, dmem_we=0 for 4 cycles; regwrite=1 with ws=4, wd_sel=1 on the cycle after ready; ST variant gives dmem_we=1 and no regwrite.
- BEQ 0x40 at PC=10: alu_zero=1 -> imem_addr=0x40; alu_zero=0 -> 11. NOP at PC=255 -> next imem_addr=0.
- HLT -> halted=1; no strobes or dmem_req for 20 cycles; reset=0 for one edge -> halted=0, imem_addr=0.
- Assert reset=0 during MEM wait; pulse dmem_ready afterwards -> dmem_req=0 after that edge; no regwrite; fetch restarts at 0.
